// File: rtl/adc_conv_scheduler.sv
// rtl/adc_conv_scheduler.sv - ADC conversion scheduler with timeout, frame check and sample FIFO
module adc_conv_scheduler #(
  parameter int DIV_W      = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 2048
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [DIV_W-1:0]            period,
  output logic                        conv_start,
  input  logic                        conv_done,
  input  logic [15:0]                 conv_data,
  output logic [11:0]                 sample_data,
  output logic                        sample_valid,
  input  logic                        sample_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        sched_miss,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        timeout_err,
  input  logic                        clear_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [TW-1:0]    to_q;
  logic             conv_start_q;
  logic [11:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      level_q;
  logic             miss_q, ferr_q, ovr_q, terr_q;

  logic tick, done_ok, push_req, frame_bad, pop, full, push, drop, miss_ev, to_ev;

  assign tick      = enable && (cnt_q == period);
  assign done_ok   = (state_q == S_WAIT) && conv_done;
  assign push_req  = done_ok && (conv_data[15:12] == 4'h0);
  assign frame_bad = done_ok && (conv_data[15:12] != 4'h0);
  assign pop       = (level_q != '0) && sample_ready;
  assign full      = (level_q == FULL_LVL);
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign miss_ev   = tick && ((state_q == S_ISSUE) || ((state_q == S_WAIT) && !conv_done));
  assign to_ev     = (state_q == S_WAIT) && !conv_done && (to_q == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!enable || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      conv_start_q <= 1'b0;
      to_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            state_q      <= S_ISSUE;
            conv_start_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q      <= S_WAIT;
          conv_start_q <= 1'b0;
          to_q         <= '0;
        end
        S_WAIT: begin
          // A tick coinciding with conv_done starts the next conversion directly.
          if (conv_done) begin
            state_q      <= tick ? S_ISSUE : S_IDLE;
            conv_start_q <= tick;
          end else if (to_q == TO_LAST) begin
            state_q <= S_IDLE;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          conv_start_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= conv_data[11:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      miss_q <= (miss_q & ~clear_err) | miss_ev;
      ferr_q <= (ferr_q & ~clear_err) | frame_bad;
      ovr_q  <= (ovr_q  & ~clear_err) | drop;
      terr_q <= (terr_q & ~clear_err) | to_ev;
    end
  end

  assign conv_start   = conv_start_q;
  assign sample_valid = (level_q != '0);
  assign sample_data  = sample_valid ? mem_q[rd_q] : 12'h000;
  assign fifo_level   = level_q;
  assign sched_miss   = miss_q;
  assign frame_err    = ferr_q;
  assign overrun      = ovr_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// tb/tb_adc_conv_scheduler.sv - directed self-checking bench for adc_conv_scheduler
module tb_adc_conv_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] period;
  logic        conv_start;
  logic        conv_done;
  logic [15:0] conv_data;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [2:0]  fifo_level;
  logic        sched_miss, frame_err, overrun, timeout_err;
  logic        clear_err;

  int checks = 0;
  int errors = 0;
  int n;

  adc_conv_scheduler #(.DIV_W(12), .FIFO_DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .conv_start(conv_start), .conv_done(conv_done), .conv_data(conv_data),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .fifo_level(fifo_level), .sched_miss(sched_miss), .frame_err(frame_err),
    .overrun(overrun), .timeout_err(timeout_err), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int cnt);
    cnt = 0;
    while (conv_start !== 1'b1 && cnt < 1000) begin
      step();
      cnt++;
    end
    if (conv_start !== 1'b1) check("start_seen", {31'd0, conv_start}, 32'd1);
  endtask

  task automatic done_after(input int d, input logic [15:0] data);
    repeat (d) step();
    conv_done = 1'b1;
    conv_data = data;
    step();
    conv_done = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; period = 12'd0; conv_done = 1'b0;
    conv_data = 16'h0; sample_ready = 1'b1; clear_err = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_start", conv_start, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_flags", {sched_miss, frame_err, overrun, timeout_err}, 0);

    // normal conversion
    period = 12'd49; enable = 1'b1;
    wait_start(n);
    check("first_start", n, 50);
    done_after(20, 16'h0ABC);
    check("t1_valid", sample_valid, 1);
    check("t1_data", sample_data, 12'hABC);
    check("t1_level", fifo_level, 1);
    step();
    check("t1_popped", sample_valid, 0);
    wait_start(n);
    check("t1_spacing", n, 28);
    check("t1_flags", {sched_miss, frame_err, overrun, timeout_err}, 0);

    // frame error
    done_after(20, 16'h1ABC);
    check("t2_level", fifo_level, 0);
    check("t2_valid", sample_valid, 0);
    check("t2_ferr", frame_err, 1);
    pulse_clear();
    check("t2_clear", frame_err, 0);
    enable = 1'b0;
    step();

    // overrun
    period = 12'd19; sample_ready = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wait_start(n);
      if (i == 1) check("t3_first_start", n, 20);
      done_after(5, 16'(i));
      if (i == 4) begin
        check("t3_level4", fifo_level, 4);
        check("t3_no_ovr", overrun, 0);
      end
    end
    enable = 1'b0;
    check("t3_ovr", overrun, 1);
    check("t3_level_full", fifo_level, 4);
    check("t3_head", sample_data, 12'h001);
    step();
    sample_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t3_pop_data", sample_data, 32'(i));
      step();
    end
    check("t3_empty", sample_valid, 0);
    check("t3_level0", fifo_level, 0);

    // timeout, then conv_done on the last allowed cycle
    pulse_clear();
    period = 12'd199; enable = 1'b1;
    wait_start(n);
    check("t4_start", n, 200);
    step();
    n = 0;
    while (timeout_err !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("t4_to_cycles", n, 64);
    pulse_clear();
    check("t4_to_clear", timeout_err, 0);
    wait_start(n);
    check("t4_next_start", n, 134);
    done_after(64, 16'h0123);
    check("t4_done_wins", timeout_err, 0);
    check("t4_valid", sample_valid, 1);
    check("t4_data", sample_data, 12'h123);
    enable = 1'b0;
    step();

    // missed tick, then done coinciding with a tick
    period = 12'd9; enable = 1'b1;
    wait_start(n);
    check("t5_start", n, 10);
    done_after(15, 16'h0555);
    check("t5_miss", sched_miss, 1);
    check("t5_data", sample_data, 12'h555);
    wait_start(n);
    check("t5_next_start", n, 4);
    sample_ready = 1'b0;
    pulse_clear();
    done_after(8, 16'h0111);
    check("t5_back2back", conv_start, 1);
    check("t5_no_miss", sched_miss, 0);
    check("t5_level1", fifo_level, 1);
    done_after(3, 16'h0222);
    check("t5_level2", fifo_level, 2);
    wait_start(n);
    check("t5_start3", n, 6);
    repeat (3) step();

    // asynchronous reset in WAIT_DONE
    reset = 1'b1;
    #1;
    check("t6_start", conv_start, 0);
    check("t6_level", fifo_level, 0);
    check("t6_valid", sample_valid, 0);
    check("t6_data", sample_data, 0);
    check("t6_flags", {sched_miss, frame_err, overrun, timeout_err}, 0);
    reset = 1'b0;
    step();
    step();
    conv_done = 1'b1; conv_data = 16'h0333;
    step();
    conv_done = 1'b0;
    check("t6_late_done", fifo_level, 0);
    check("t6_late_valid", sample_valid, 0);
    wait_start(n);
    check("t6_restart", n, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
